// File: rtl/video_write_scheduler_if.sv
// Pixel-write bus bundle: CPU store port, fill command port and framebuffer write port.
interface video_write_scheduler_if #(
  parameter int unsigned W = 8,
  parameter int unsigned H = 8
);
  logic             cpu_write;
  logic [W+H-1:0]   cpu_address;
  logic [31:0]      cpu_data;
  logic             cpu_ready;

  logic             fill_start;
  logic [W-1:0]     fill_x;
  logic [H-1:0]     fill_y;
  logic [W:0]       fill_width;
  logic [H:0]       fill_height;
  logic [23:0]      fill_color;
  logic             fill_busy;
  logic             fill_done;

  logic             video_write;
  logic [W+H-1:0]   video_address;
  logic [31:0]      video_data;

  // Requester side: issues CPU stores and fill commands, observes the framebuffer port.
  modport master (
    output cpu_write, cpu_address, cpu_data,
    output fill_start, fill_x, fill_y, fill_width, fill_height, fill_color,
    input  cpu_ready, fill_busy, fill_done,
    input  video_write, video_address, video_data
  );

  // Scheduler side.
  modport slave (
    input  cpu_write, cpu_address, cpu_data,
    input  fill_start, fill_x, fill_y, fill_width, fill_height, fill_color,
    output cpu_ready, fill_busy, fill_done,
    output video_write, video_address, video_data
  );
endinterface

// File: rtl/video_write_scheduler.sv
// Merges CPU pixel stores and a rectangle-fill engine onto the single framebuffer
// write port. CPU has priority; the fill engine is guaranteed one slot after
// MAX_CPU_RUN consecutive CPU grants.
module video_write_scheduler #(
  parameter int unsigned SCREEN_WIDTH_BIT_WIDTH  = 8,
  parameter int unsigned SCREEN_HEIGHT_BIT_WIDTH = 8,
  parameter int unsigned MAX_CPU_RUN             = 4
) (
  input logic                    clock,
  input logic                    reset,
  video_write_scheduler_if.slave bus
);

  localparam int unsigned W  = SCREEN_WIDTH_BIT_WIDTH;
  localparam int unsigned H  = SCREEN_HEIGHT_BIT_WIDTH;
  localparam int unsigned CW = $clog2(MAX_CPU_RUN + 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t          state;
  logic [W-1:0]    org_x;
  logic [W-1:0]    end_x;
  logic [H-1:0]    end_y;
  logic [23:0]     color;
  logic [W-1:0]    cx;
  logic [H-1:0]    cy;
  logic [CW-1:0]   starve_cnt;

  logic            fill_busy;
  logic            fill_done;
  logic            video_write;
  logic [W+H-1:0]  video_address;
  logic [31:0]     video_data;

  logic [W:0]      room_x;
  logic [H:0]      room_y;
  logic [W:0]      eff_w;
  logic [H:0]      eff_h;
  logic [W-1:0]    new_end_x;
  logic [H-1:0]    new_end_y;
  logic            cpu_ready_c;
  logic            cpu_grant;
  logic            fill_grant;
  logic            last_col;
  logic            last_pix;

  // Clip the incoming rectangle to the screen and derive its inclusive far corner.
  always_comb begin
    room_x    = {1'b1, W'(0)} - {1'b0, bus.fill_x};
    room_y    = {1'b1, H'(0)} - {1'b0, bus.fill_y};
    eff_w     = (bus.fill_width  < room_x) ? bus.fill_width  : room_x;
    eff_h     = (bus.fill_height < room_y) ? bus.fill_height : room_y;
    new_end_x = bus.fill_x + W'(eff_w - (W+1)'(1));
    new_end_y = bus.fill_y + H'(eff_h - (H+1)'(1));
  end

  // Slot arbitration: CPU wins unless the fill engine has been starved too long.
  always_comb begin
    cpu_ready_c = (state == IDLE) || (starve_cnt != CW'(MAX_CPU_RUN));
    cpu_grant   = bus.cpu_write && cpu_ready_c;
    fill_grant  = (state == FILL) && !cpu_grant;
    last_col    = (cx == end_x);
    last_pix    = last_col && (cy == end_y);
  end

  // Scheduler FSM, fill cursor, starvation counter and registered write port.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      org_x         <= '0;
      end_x         <= '0;
      end_y         <= '0;
      color         <= '0;
      cx            <= '0;
      cy            <= '0;
      starve_cnt    <= '0;
      fill_busy     <= 1'b0;
      fill_done     <= 1'b0;
      video_write   <= 1'b0;
      video_address <= '0;
      video_data    <= '0;
    end else begin
      video_write <= 1'b0;
      fill_done   <= 1'b0;

      if (cpu_grant) begin
        video_write   <= 1'b1;
        video_address <= bus.cpu_address;
        video_data    <= bus.cpu_data;
      end else if (fill_grant) begin
        video_write   <= 1'b1;
        video_address <= {cy, cx};
        video_data    <= {8'h00, color};
      end

      case (state)
        IDLE: begin
          if (bus.fill_start) begin
            if ((eff_w == '0) || (eff_h == '0)) begin
              fill_done <= 1'b1;
            end else begin
              org_x      <= bus.fill_x;
              end_x      <= new_end_x;
              end_y      <= new_end_y;
              color      <= bus.fill_color;
              cx         <= bus.fill_x;
              cy         <= bus.fill_y;
              starve_cnt <= '0;
              fill_busy  <= 1'b1;
              state      <= FILL;
            end
          end
        end
        FILL: begin
          if (cpu_grant) begin
            if (starve_cnt != CW'(MAX_CPU_RUN)) starve_cnt <= starve_cnt + CW'(1);
          end else begin
            starve_cnt <= '0;
            if (last_pix) begin
              fill_busy <= 1'b0;
              fill_done <= 1'b1;
              state     <= IDLE;
            end else if (last_col) begin
              cx <= org_x;
              cy <= cy + H'(1);
            end else begin
              cx <= cx + W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cpu_ready     = cpu_ready_c;
  assign bus.fill_busy     = fill_busy;
  assign bus.fill_done     = fill_done;
  assign bus.video_write   = video_write;
  assign bus.video_address = video_address;
  assign bus.video_data    = video_data;

endmodule

// File: tb/tb_video_write_scheduler.sv
// Directed bench for video_write_scheduler: fills, clipping, zero size,
// starvation bound, CPU path, ignored restart and mid-fill reset.
module tb_video_write_scheduler;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  video_write_scheduler_if #(.W(8), .H(8)) bus ();

  video_write_scheduler #(
    .SCREEN_WIDTH_BIT_WIDTH (8),
    .SCREEN_HEIGHT_BIT_WIDTH(8),
    .MAX_CPU_RUN            (4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.cpu_write   = 1'b0;
    bus.cpu_address = '0;
    bus.cpu_data    = '0;
    bus.fill_start  = 1'b0;
    bus.fill_x      = '0;
    bus.fill_y      = '0;
    bus.fill_width  = '0;
    bus.fill_height = '0;
    bus.fill_color  = '0;
  endtask

  task automatic start_fill(input logic [7:0] x, input logic [7:0] y,
                            input logic [8:0] w, input logic [8:0] h,
                            input logic [23:0] c);
    bus.fill_start  = 1'b1;
    bus.fill_x      = x;
    bus.fill_y      = y;
    bus.fill_width  = w;
    bus.fill_height = h;
    bus.fill_color  = c;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    step();
    step();
    reset = 1'b0;
    step();
    total++; if (bus.video_write !== 1'b0) begin bad++; $display("FAIL reset_vw got=%b want=0", bus.video_write); end
    total++; if (bus.video_address !== 16'h0000) begin bad++; $display("FAIL reset_addr got=%h want=0000", bus.video_address); end
    total++; if (bus.video_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", bus.video_data); end
    total++; if (bus.fill_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.fill_busy); end
    total++; if (bus.fill_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.fill_done); end
    total++; if (bus.cpu_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.cpu_ready); end
  endtask

  task automatic test_basic_fill();
    logic [15:0] exp_addr [6];
    exp_addr[0] = 16'h0302; exp_addr[1] = 16'h0303; exp_addr[2] = 16'h0304;
    exp_addr[3] = 16'h0402; exp_addr[4] = 16'h0403; exp_addr[5] = 16'h0404;
    start_fill(8'd2, 8'd3, 9'd3, 9'd2, 24'hABCDEF);
    step();
    bus.fill_start = 1'b0;
    total++; if (bus.fill_busy !== 1'b1) begin bad++; $display("FAIL basic_busy_rise got=%b want=1", bus.fill_busy); end
    total++; if (bus.video_write !== 1'b0) begin bad++; $display("FAIL basic_vw_early got=%b want=0", bus.video_write); end
    for (int i = 0; i < 6; i++) begin
      step();
      total++; if (bus.video_write !== 1'b1) begin bad++; $display("FAIL basic_vw[%0d] got=%b want=1", i, bus.video_write); end
      total++; if (bus.video_address !== exp_addr[i]) begin bad++; $display("FAIL basic_addr[%0d] got=%h want=%h", i, bus.video_address, exp_addr[i]); end
      total++; if (bus.video_data !== 32'h00ABCDEF) begin bad++; $display("FAIL basic_data[%0d] got=%h want=00abcdef", i, bus.video_data); end
      total++; if (bus.fill_done !== (i == 5)) begin bad++; $display("FAIL basic_done[%0d] got=%b want=%b", i, bus.fill_done, (i == 5)); end
      total++; if (bus.fill_busy !== (i != 5)) begin bad++; $display("FAIL basic_busy[%0d] got=%b want=%b", i, bus.fill_busy, (i != 5)); end
    end
    step();
    total++; if (bus.video_write !== 1'b0) begin bad++; $display("FAIL basic_vw_after got=%b want=0", bus.video_write); end
    total++; if (bus.video_address !== 16'h0404) begin bad++; $display("FAIL basic_addr_hold got=%h want=0404", bus.video_address); end
  endtask

  task automatic test_clip();
    logic [15:0] exp_addr [2];
    exp_addr[0] = 16'hFFFE; exp_addr[1] = 16'hFFFF;
    start_fill(8'd254, 8'd255, 9'd5, 9'd5, 24'h00FF00);
    step();
    bus.fill_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (bus.video_write !== 1'b1) begin bad++; $display("FAIL clip_vw[%0d] got=%b want=1", i, bus.video_write); end
      total++; if (bus.video_address !== exp_addr[i]) begin bad++; $display("FAIL clip_addr[%0d] got=%h want=%h", i, bus.video_address, exp_addr[i]); end
      total++; if (bus.fill_done !== (i == 1)) begin bad++; $display("FAIL clip_done[%0d] got=%b want=%b", i, bus.fill_done, (i == 1)); end
    end
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (bus.video_write !== 1'b0) begin bad++; $display("FAIL clip_extra_vw[%0d] got=%b want=0", i, bus.video_write); end
    end
  endtask

  task automatic test_zero_size();
    start_fill(8'd10, 8'd10, 9'd0, 9'd7, 24'h123456);
    step();
    bus.fill_start = 1'b0;
    total++; if (bus.fill_done !== 1'b1) begin bad++; $display("FAIL zero_done got=%b want=1", bus.fill_done); end
    total++; if (bus.fill_busy !== 1'b0) begin bad++; $display("FAIL zero_busy got=%b want=0", bus.fill_busy); end
    total++; if (bus.video_write !== 1'b0) begin bad++; $display("FAIL zero_vw got=%b want=0", bus.video_write); end
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (bus.video_write !== 1'b0) begin bad++; $display("FAIL zero_vw_after[%0d] got=%b want=0", i, bus.video_write); end
      total++; if (bus.fill_done !== 1'b0) begin bad++; $display("FAIL zero_done_after[%0d] got=%b want=0", i, bus.fill_done); end
      total++; if (bus.fill_busy !== 1'b0) begin bad++; $display("FAIL zero_busy_after[%0d] got=%b want=0", i, bus.fill_busy); end
    end
  endtask

  task automatic test_starvation();
    logic [15:0] exp_fill [4];
    logic        exp_rdy;
    logic [31:0] cdata;
    exp_fill[0] = 16'h2010; exp_fill[1] = 16'h2011;
    exp_fill[2] = 16'h2110; exp_fill[3] = 16'h2111;
    bus.cpu_write   = 1'b1;
    bus.cpu_address = 16'h00AA;
    bus.cpu_data    = 32'hCAFE0000;
    start_fill(8'h10, 8'h20, 9'd2, 9'd2, 24'h123456);
    step();
    bus.fill_start = 1'b0;
    total++; if (bus.video_address !== 16'h00AA) begin bad++; $display("FAIL starve_idle_cpu got=%h want=00aa", bus.video_address); end
    for (int k = 0; k < 20; k++) begin
      cdata = 32'hC0000000 + 32'(k);
      bus.cpu_data = cdata;
      exp_rdy = ((k % 5) != 4);
      total++; if (bus.cpu_ready !== exp_rdy) begin bad++; $display("FAIL starve_ready[%0d] got=%b want=%b", k, bus.cpu_ready, exp_rdy); end
      step();
      total++; if (bus.video_write !== 1'b1) begin bad++; $display("FAIL starve_vw[%0d] got=%b want=1", k, bus.video_write); end
      if (exp_rdy) begin
        total++; if (bus.video_data !== cdata) begin bad++; $display("FAIL starve_cpu_data[%0d] got=%h want=%h", k, bus.video_data, cdata); end
      end else begin
        total++; if (bus.video_address !== exp_fill[k/5]) begin bad++; $display("FAIL starve_fill_addr[%0d] got=%h want=%h", k, bus.video_address, exp_fill[k/5]); end
        total++; if (bus.video_data !== 32'h00123456) begin bad++; $display("FAIL starve_fill_data[%0d] got=%h want=00123456", k, bus.video_data); end
      end
      total++; if (bus.fill_done !== (k == 19)) begin bad++; $display("FAIL starve_done[%0d] got=%b want=%b", k, bus.fill_done, (k == 19)); end
    end
    total++; if (bus.fill_busy !== 1'b0) begin bad++; $display("FAIL starve_busy_end got=%b want=0", bus.fill_busy); end
    bus.cpu_write = 1'b0;
    step();
    total++; if (bus.video_write !== 1'b0) begin bad++; $display("FAIL starve_vw_end got=%b want=0", bus.video_write); end
  endtask

  task automatic test_mixed();
    logic [15:0] exp_addr [4];
    exp_addr[0] = 16'h0605; exp_addr[1] = 16'h0606;
    exp_addr[2] = 16'h0705; exp_addr[3] = 16'h0706;
    bus.cpu_write   = 1'b1;
    bus.cpu_address = 16'h1234;
    bus.cpu_data    = 32'hDEADBEEF;
    step();
    bus.cpu_write = 1'b0;
    total++; if (bus.video_write !== 1'b1) begin bad++; $display("FAIL cpu_vw got=%b want=1", bus.video_write); end
    total++; if (bus.video_address !== 16'h1234) begin bad++; $display("FAIL cpu_addr got=%h want=1234", bus.video_address); end
    total++; if (bus.video_data !== 32'hDEADBEEF) begin bad++; $display("FAIL cpu_data got=%h want=deadbeef", bus.video_data); end
    step();
    total++; if (bus.video_write !== 1'b0) begin bad++; $display("FAIL cpu_vw_pulse got=%b want=0", bus.video_write); end
    total++; if (bus.video_data !== 32'hDEADBEEF) begin bad++; $display("FAIL cpu_data_hold got=%h want=deadbeef", bus.video_data); end
    start_fill(8'd5, 8'd6, 9'd2, 9'd2, 24'h0000FF);
    step();
    bus.fill_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) start_fill(8'd0, 8'd0, 9'd10, 9'd10, 24'hFFFFFF);
      else bus.fill_start = 1'b0;
      step();
      total++; if (bus.video_address !== exp_addr[i]) begin bad++; $display("FAIL restart_addr[%0d] got=%h want=%h", i, bus.video_address, exp_addr[i]); end
      total++; if (bus.video_data !== 32'h000000FF) begin bad++; $display("FAIL restart_data[%0d] got=%h want=000000ff", i, bus.video_data); end
      total++; if (bus.fill_done !== (i == 3)) begin bad++; $display("FAIL restart_done[%0d] got=%b want=%b", i, bus.fill_done, (i == 3)); end
    end
    bus.fill_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (bus.video_write !== 1'b0) begin bad++; $display("FAIL restart_extra_vw[%0d] got=%b want=0", i, bus.video_write); end
      total++; if (bus.fill_busy !== 1'b0) begin bad++; $display("FAIL restart_busy[%0d] got=%b want=0", i, bus.fill_busy); end
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [15:0] exp_addr [3];
    exp_addr[0] = 16'h0000; exp_addr[1] = 16'h0001; exp_addr[2] = 16'h0002;
    start_fill(8'd0, 8'd0, 9'd3, 9'd2, 24'h111111);
    step();
    bus.fill_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (bus.video_address !== exp_addr[i]) begin bad++; $display("FAIL abort_addr[%0d] got=%h want=%h", i, bus.video_address, exp_addr[i]); end
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (bus.video_write !== 1'b0) begin bad++; $display("FAIL abort_vw got=%b want=0", bus.video_write); end
    total++; if (bus.fill_busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", bus.fill_busy); end
    for (int i = 0; i < 8; i++) begin
      step();
      total++; if (bus.video_write !== 1'b0) begin bad++; $display("FAIL abort_vw_after[%0d] got=%b want=0", i, bus.video_write); end
      total++; if (bus.fill_done !== 1'b0) begin bad++; $display("FAIL abort_done_after[%0d] got=%b want=0", i, bus.fill_done); end
    end
    start_fill(8'd1, 8'd1, 9'd1, 9'd1, 24'h222222);
    step();
    bus.fill_start = 1'b0;
    total++; if (bus.fill_busy !== 1'b1) begin bad++; $display("FAIL post_reset_busy got=%b want=1", bus.fill_busy); end
    step();
    total++; if (bus.video_write !== 1'b1) begin bad++; $display("FAIL post_reset_vw got=%b want=1", bus.video_write); end
    total++; if (bus.video_address !== 16'h0101) begin bad++; $display("FAIL post_reset_addr got=%h want=0101", bus.video_address); end
    total++; if (bus.video_data !== 32'h00222222) begin bad++; $display("FAIL post_reset_data got=%h want=00222222", bus.video_data); end
    total++; if (bus.fill_done !== 1'b1) begin bad++; $display("FAIL post_reset_done got=%b want=1", bus.fill_done); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_basic_fill();
    test_clip();
    test_zero_size();
    test_starvation();
    test_mixed();
    test_reset_mid_fill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_write_scheduler.md
# video_write_scheduler

Sequences all pixel writes into the video framebuffer controller. It merges single-pixel CPU stores with a hardware rectangle-fill engine onto the framebuffer's single write port (write/address/data). CPU stores have priority, with a bounded-starvation guarantee for the fill engine. It sits between the memory-mapped video region and the framebuffer, and drives that port exclusively.

## Interface
- SCREEN_WIDTH_BIT_WIDTH, 8, x coordinate width (W)
- SCREEN_HEIGHT_BIT_WIDTH, 8, y coordinate width (H)
- MAX_CPU_RUN, 4, consecutive CPU grants allowed while a fill pixel is pending (≥1)
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- cpu_write  in  1  CPU pixel-store request
- cpu_address  in  W+H  CPU pixel address, {y, x}
- cpu_data  in  32  CPU pixel value, bits [23:0] meaningful
- cpu_ready  out  1  combinational; store accepted in the cycle where cpu_write && cpu_ready
- fill_start  in  1  one-cycle fill command strobe
- fill_x, fill_y  in  W / H  rectangle origin
- fill_width, fill_height  in  W+1 / H+1  rectangle size in pixels
- fill_color  in  24  fill value
- fill_busy  out  1  fill in progress
- fill_done  out  1  one-cycle completion pulse
- video_write  out  1  registered write strobe to framebuffer
- video_address  out  W+H  registered, {y, x} (row-major, y*2^W + x)
- video_data  out  32  registered, {8'h00, color} for fills, cpu_data verbatim for CPU

## Operation
- FSM states: IDLE, FILL.
- IDLE:
  - fill_start latches origin, color and clipped size.
  - eff_w = min(fill_width, 2^W − fill_x); eff_h = min(fill_height, 2^H − fill_y).
  - If eff_w==0 or eff_h==0: stay IDLE, pulse fill_done next cycle, no writes.
  - Otherwise go to FILL with cursor (cx, cy) = (fill_x, fill_y).
- fill_start while FILL: ignored; latched values unchanged.
- Arbitration, each cycle:
  - IDLE: cpu_ready=1.
  - FILL: cpu_ready=0 only if starve_cnt == MAX_CPU_RUN; that cycle grants the fill pixel.
  - Otherwise cpu_ready=1. cpu_write wins the slot; else the fill pixel is granted.
- starve_cnt: +1 on each CPU grant while in FILL. Cleared on every fill grant and on entry to FILL. Saturates at MAX_CPU_RUN.
- Fill grant issues pixel (cx, cy), then advances the cursor:
  - cx+1.
  - At cx == fill_x+eff_w−1: cx=fill_x, cy+1.
  - At the last pixel (end of row fill_y+eff_h−1): return to IDLE.
- Pixels are written strictly in row-major order, left to right, top to bottom. Exactly eff_w*eff_h fill writes per command.
- Cursor arithmetic uses W+1 / H+1 bit intermediates; no address wrap-around is possible after clipping.
- Reset, including mid-fill: state IDLE, fill aborted, no further fill writes, starve_cnt=0.

## Timing
- Reset values: video_write=0, video_address=0, video_data=0, fill_busy=0, fill_done=0. cpu_ready=1 in the cycle after reset deasserts.
- Write latency: the grant in cycle N appears on video_* in cycle N+1, as a one-cycle video_write pulse. At most one write per cycle.
- video_address and video_data hold their last value when video_write=0.
- fill_busy goes high the cycle after an accepted fill_start and low the cycle after the last fill grant.
- fill_done pulses in that same cycle, coincident with the final pixel's video_write.
- For a zero-size command, fill_done pulses the cycle after fill_start and fill_busy stays 0.
- Throughput: with no CPU traffic, a fill of P pixels completes in P cycles after fill_busy rises.
- With continuous CPU traffic, the fill gets one slot every MAX_CPU_RUN+1 cycles.

## Test plan
- Reset then fill (x=2, y=3, w=3, h=2, color=0xABCDEF), no CPU:
  - 6 writes on consecutive cycles, addresses 0x0302, 0x0303, 0x0304, 0x0402, 0x0403, 0x0404.
  - video_data = 0x00ABCDEF.
  - fill_done coincides with the 6th write.
- Clipping: fill x=254, y=255, w=5, h=5 → exactly 2 writes (0xFFFE, 0xFFFF), then fill_done.
- Zero size: fill w=0, h=7 → no video_write, fill_busy stays 0, fill_done one cycle after start.
- Starvation: cpu_write held high continuously during a 4-pixel fill (MAX_CPU_RUN=4):
  - Pattern of 4 CPU writes, 1 fill write, repeating.
  - cpu_ready low exactly in the fill-grant cycles.
  - Fill finishes in 20 cycles.
- Mixed: CPU write to 0x1234 with data 0xDEADBEEF while IDLE → one-cycle later video_write, address 0x1234, data 0xDEADBEEF.
  - A second fill_start mid-fill is ignored: pixel count and origin unchanged.
- Reset asserted after 3 of 6 fill pixels → no further fill writes, fill_busy=0, fill_done never pulses; a new fill after reset runs normally.
